// File: rtl/uart_rx_fifo_feeder.sv
// uart_rx_fifo_feeder: oversampling 8N1 UART receiver that writes good frames into an async FIFO; optional even parity via UART_RX_PARITY_EN; ports w_clk, w_rst, rx, fifo_full in; w_en, w_data, frame_err, overflow, busy out
module uart_rx_fifo_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  rx,
  input  logic                  fifo_full,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  frame_err,
  output logic                  overflow,
  output logic                  busy
);
  localparam int BW = $clog2(DATA_WIDTH) + 1;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic rx_m_q, rx_s_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, w_data_q, w_data_d;
  logic w_en_q, w_en_d, frame_err_q, frame_err_d, overflow_q, overflow_d, busy_q, busy_d;
  logic bit_end, bad_frame;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  assign bad_frame = !rx_s_q || perr_q;
`else
  assign bad_frame = !rx_s_q;
`endif
  assign bit_end = cnt_q == CNT_WIDTH'(CLKS_PER_BIT - 1);
  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == IDLE) ? '0 : cnt_q + CNT_WIDTH'(1);
    bit_idx_d   = bit_idx_q;
    sr_d        = sr_q;
    w_data_d    = w_data_q;
    w_en_d      = 1'b0;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d      = perr_q;
`endif
    case (state_q)
      IDLE: if (!rx_s_q) state_d = START;
      START: if (cnt_q == CNT_WIDTH'(CLKS_PER_BIT/2 - 1)) begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = rx_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
`endif
      end
      DATA: if (bit_end) begin
        cnt_d     = '0;
        sr_d      = {rx_s_q, sr_q[DATA_WIDTH-1:1]};
        bit_idx_d = bit_idx_q + BW'(1);
`ifdef UART_RX_PARITY_EN
        if (bit_idx_q == BW'(DATA_WIDTH - 1)) state_d = PARITY;
`else
        if (bit_idx_q == BW'(DATA_WIDTH - 1)) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) begin
        cnt_d   = '0;
        perr_d  = ^{sr_q, rx_s_q};
        state_d = STOP;
      end
`endif
      STOP: if (bit_end) begin
        cnt_d       = '0;
        state_d     = IDLE;
        frame_err_d = bad_frame;
        overflow_d  = !bad_frame && fifo_full;
        w_en_d      = !bad_frame && !fifo_full;
        w_data_d    = (!bad_frame && !fifo_full) ? sr_q : w_data_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge w_clk or posedge w_rst)
    if (w_rst) begin
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      sr_q        <= '0;
      w_data_q    <= '0;
      w_en_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      rx_m_q      <= rx;
      rx_s_q      <= rx_m_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      sr_q        <= sr_d;
      w_data_q    <= w_data_d;
      w_en_q      <= w_en_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  assign w_en      = w_en_q;
  assign w_data    = w_data_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// tb_uart_rx_fifo_feeder: directed-frame self-checking bench for uart_rx_fifo_feeder
module tb_uart_rx_fifo_feeder;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171, FRM = 176;
`else
  localparam int LAT = 155, FRM = 160;
`endif
  logic w_clk = 1'b0, w_rst = 1'b1, rx = 1'b1, fifo_full = 1'b0;
  logic w_en, frame_err, overflow, busy;
  logic [7:0] w_data;
  int cyc = 0, vec = 0, bad = 0;
  int wen_n = 0, ferr_n = 0, ovf_n = 0, busy_n = 0;
  logic [7:0] data_log[$];
  int time_log[$];
  uart_rx_fifo_feeder dut (
    .w_clk(w_clk), .w_rst(w_rst), .rx(rx), .fifo_full(fifo_full),
    .w_en(w_en), .w_data(w_data), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );
  always #5 w_clk = ~w_clk;
  always @(posedge w_clk) cyc <= cyc + 1;
  always @(negedge w_clk) begin
    if (w_en) begin
      wen_n++;
      data_log.push_back(w_data);
      time_log.push_back(cyc);
    end
    if (frame_err) ferr_n++;
    if (overflow) ovf_n++;
    if (busy) busy_n++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge w_clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pflip, output int t0);
    rx = 1'b0;
    t0 = cyc;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ pflip;
    idle(16);
`endif
    rx = stop_b;
    idle(16);
    rx = 1'b1;
  endtask
  initial begin
    int t0, t1, t2, w0, f0, o0, b0;
    idle(3);
    chk("rst_w_en", w_en, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    w_rst = 1'b0;
    idle(5);
    w0 = wen_n; f0 = ferr_n; o0 = ovf_n;
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    idle(10);
    chk("a5_count", wen_n - w0, 1);
    chk("a5_data", data_log[w0], 8'hA5);
    chk("a5_latency_ok", (time_log[w0] - t0 >= LAT - 1) && (time_log[w0] - t0 <= LAT + 1), 1);
    chk("a5_no_ferr", ferr_n - f0, 0);
    chk("a5_no_ovf", ovf_n - o0, 0);
    w0 = wen_n;
    send_frame(8'h00, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, 1'b0, t1);
    send_frame(8'h3C, 1'b1, 1'b0, t2);
    idle(10);
    chk("b2b_count", wen_n - w0, 3);
    chk("b2b_data0", data_log[w0], 8'h00);
    chk("b2b_data1", data_log[w0+1], 8'hFF);
    chk("b2b_data2", data_log[w0+2], 8'h3C);
    chk("b2b_gap01", (time_log[w0+1] - time_log[w0] >= FRM - 1) && (time_log[w0+1] - time_log[w0] <= FRM + 1), 1);
    chk("b2b_gap12", (time_log[w0+2] - time_log[w0+1] >= FRM - 1) && (time_log[w0+2] - time_log[w0+1] <= FRM + 1), 1);
    w0 = wen_n; f0 = ferr_n; o0 = ovf_n;
    send_frame(8'h5A, 1'b0, 1'b0, t0);
    idle(30);
    chk("stop_low_ferr", ferr_n - f0, 1);
    chk("stop_low_no_wen", wen_n - w0, 0);
    chk("stop_low_no_ovf", ovf_n - o0, 0);
    chk("stop_low_hold", w_data, 8'h3C);
    send_frame(8'h81, 1'b1, 1'b0, t0);
    idle(10);
    chk("after_ferr_count", wen_n - w0, 1);
    chk("after_ferr_data", w_data, 8'h81);
    w0 = wen_n; f0 = ferr_n; o0 = ovf_n;
    fifo_full = 1'b1;
    send_frame(8'h42, 1'b1, 1'b0, t0);
    idle(10);
    chk("full_ovf", ovf_n - o0, 1);
    chk("full_no_wen", wen_n - w0, 0);
    chk("full_no_ferr", ferr_n - f0, 0);
    chk("full_hold", w_data, 8'h81);
    fifo_full = 1'b0;
    send_frame(8'h43, 1'b1, 1'b0, t0);
    idle(10);
    chk("unfull_count", wen_n - w0, 1);
    chk("unfull_data", w_data, 8'h43);
    w0 = wen_n; f0 = ferr_n; o0 = ovf_n; b0 = busy_n;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    chk("glitch_busy_seen", busy_n > b0, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_quiet", (wen_n - w0) + (ferr_n - f0) + (ovf_n - o0), 0);
    w0 = wen_n; f0 = ferr_n; o0 = ovf_n;
    rx = 1'b0;
    idle(16);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      idle(16);
    end
    rx = 1'b1;
    idle(8);
    w_rst = 1'b1;
    #1;
    chk("midrst_w_en", w_en, 0);
    chk("midrst_w_data", w_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ferr_ovf", {frame_err, overflow}, 0);
    idle(2);
    w_rst = 1'b0;
    idle(5);
    chk("midrst_no_pulses", (wen_n - w0) + (ferr_n - f0) + (ovf_n - o0), 0);
    send_frame(8'h99, 1'b1, 1'b0, t0);
    idle(10);
    chk("midrst_count", wen_n - w0, 1);
    chk("midrst_data", w_data, 8'h99);
`ifdef UART_RX_PARITY_EN
    w0 = wen_n; f0 = ferr_n;
    send_frame(8'h07, 1'b1, 1'b1, t0);
    idle(10);
    chk("par_bad_ferr", ferr_n - f0, 1);
    chk("par_bad_no_wen", wen_n - w0, 0);
    send_frame(8'h07, 1'b1, 1'b0, t0);
    idle(10);
    chk("par_good_count", wen_n - w0, 1);
    chk("par_good_data", w_data, 8'h07);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
